// File: rtl/dial_sequencer.sv
// ============================================================================
// dial_sequencer: keypad number entry buffer and paced digit playout.
// Revision 1.0
// ============================================================================
`default_nettype none

module dial_sequencer #(
  parameter int DIGITS     = 11,
  parameter int GAP_CYCLES = 5_000_000,
  parameter int CNT_W      = 23
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  output logic [4*DIGITS-1:0] number,
  output logic [3:0]          digit_cnt,
  output logic                busy,
  output logic [3:0]          digit_out,
  output logic                digit_valid,
  input  logic                digit_ready,
  output logic                dial_done,
  output logic                err
);

  localparam int NW    = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [3:0]       FULL     = 4'(DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  localparam logic [3:0] K_BACK  = 4'hA;
  localparam logic [3:0] K_CLEAR = 4'hB;
  localparam logic [3:0] K_DIAL  = 4'hC;
  localparam logic [3:0] K_HANG  = 4'hD;

  typedef enum logic [1:0] {
    S_ENTRY = 2'd0,
    S_SEND  = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [NW-1:0]    number_n;
  logic [3:0]       cnt_n;
  logic [IDX_W-1:0] send_idx, idx_n;
  logic [CNT_W-1:0] gap_cnt, gap_n;
  logic [3:0]       dout_n;
  logic             done_n, err_n;
  logic             hang;

  function automatic logic [3:0] nibble(input logic [NW-1:0] value,
                                        input logic [IDX_W-1:0] idx);
    logic [NW-1:0] shifted;
    shifted = value >> {idx, 2'b00};
    return shifted[3:0];
  endfunction

  assign busy        = (state != S_ENTRY);
  assign digit_valid = (state == S_SEND);
  assign hang        = key_valid && (key_code == K_HANG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_ENTRY;
      number    <= '0;
      digit_cnt <= '0;
      send_idx  <= '0;
      gap_cnt   <= '0;
      digit_out <= '0;
      dial_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      number    <= number_n;
      digit_cnt <= cnt_n;
      send_idx  <= idx_n;
      gap_cnt   <= gap_n;
      digit_out <= dout_n;
      dial_done <= done_n;
      err       <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    number_n = number;
    cnt_n    = digit_cnt;
    idx_n    = send_idx;
    gap_n    = gap_cnt;
    dout_n   = digit_out;
    done_n   = 1'b0;
    err_n    = 1'b0;
    case (state)
      S_ENTRY: begin
        if (key_valid) begin
          if (key_code <= 4'd9) begin
            if (digit_cnt < FULL) begin
              number_n = {number[NW-5:0], key_code};
              cnt_n    = digit_cnt + 4'd1;
            end else begin
              err_n = 1'b1;
            end
          end else if (key_code == K_BACK) begin
            if (digit_cnt != 4'd0) begin
              number_n = number >> 4;
              cnt_n    = digit_cnt - 4'd1;
            end else begin
              err_n = 1'b1;
            end
          end else if (key_code == K_CLEAR) begin
            number_n = '0;
            cnt_n    = '0;
          end else if (key_code == K_DIAL) begin
            if (digit_cnt == FULL) begin
              state_n = S_SEND;
              idx_n   = LAST_IDX;
              dout_n  = number[NW-1 -: 4];
            end else begin
              err_n = 1'b1;
            end
          end
        end
      end
      S_SEND: begin
        // Hang-up wins over a same-cycle transfer; that digit is not followed up.
        if (hang) begin
          state_n  = S_ENTRY;
          number_n = '0;
          cnt_n    = '0;
        end else if (digit_ready) begin
          if (send_idx == '0) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end else begin
            state_n = S_GAP;
            idx_n   = send_idx - 1'b1;
            gap_n   = '0;
          end
        end
      end
      S_GAP: begin
        if (hang) begin
          state_n  = S_ENTRY;
          number_n = '0;
          cnt_n    = '0;
        end else if (gap_cnt == GAP_LAST) begin
          state_n = S_SEND;
          dout_n  = nibble(number, send_idx);
        end else begin
          gap_n = gap_cnt + 1'b1;
        end
      end
      S_DONE: begin
        if (key_valid && ((key_code == K_CLEAR) || (key_code == K_HANG))) begin
          state_n  = S_ENTRY;
          number_n = '0;
          cnt_n    = '0;
        end
      end
      default: state_n = S_ENTRY;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_dial_sequencer.sv
// Scoreboard bench for dial_sequencer: directed key sequences, queued expected digits.
`default_nettype none

module tb_dial_sequencer;

  localparam int DIGITS = 11;
  localparam int GAP    = 4;
  localparam int NW     = 4 * DIGITS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          key_valid = 1'b0;
  logic [3:0]    key_code = 4'h0;
  logic [NW-1:0] number;
  logic [3:0]    digit_cnt;
  logic          busy;
  logic [3:0]    digit_out;
  logic          digit_valid;
  logic          digit_ready = 1'b1;
  logic          dial_done;
  logic          err;

  dial_sequencer #(.DIGITS(DIGITS), .GAP_CYCLES(GAP), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .number(number), .digit_cnt(digit_cnt), .busy(busy),
    .digit_out(digit_out), .digit_valid(digit_valid),
    .digit_ready(digit_ready), .dial_done(dial_done), .err(err)
  );

  always #5 clk = ~clk;

  int vecs = 0, fails = 0;
  int xfer_cnt = 0, err_cnt = 0, done_cnt = 0;
  logic [3:0] exp_q[$];
  int idle = 0;
  bit have_prev = 0, prev_valid = 0;

  localparam logic [NW-1:0] FULL_NUM = 44'h13800138000;
  int seq[11] = '{1, 3, 8, 0, 0, 1, 3, 8, 0, 0, 0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each transfer, measures idle spacing, counts pulses.
  always @(negedge clk) begin
    if (rst) begin
      have_prev = 0; idle = 0; prev_valid = 0;
    end else begin
      if (!busy) begin
        have_prev = 0; idle = 0;
      end else if (!digit_valid) begin
        idle++;
      end
      if (digit_valid && !prev_valid) begin
        if (have_prev) check("gap_idle", idle, GAP);
        have_prev = 1; idle = 0;
      end
      if (digit_valid && digit_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) check("unexpected_digit", digit_out, 4'hF);
        else check("digit_out", digit_out, exp_q.pop_front());
      end
      if (err) err_cnt++;
      if (dial_done) done_cnt++;
      prev_valid = digit_valid;
    end
  end

  task automatic press(input logic [3:0] k);
    @(posedge clk); #1;
    key_valid = 1'b1; key_code = k;
    @(posedge clk); #1;
    key_valid = 1'b0; key_code = 4'hA;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic enter_full();
    for (int i = 0; i < DIGITS; i++) press(4'(seq[i]));
  endtask

  task automatic queue_full();
    for (int i = 0; i < DIGITS; i++) exp_q.push_back(4'(seq[i]));
  endtask

  task automatic wait_xfer(input int n);
    int c = 0;
    while (xfer_cnt < n && c < 2000) begin @(posedge clk); #1; c++; end
    check("xfer_wait", xfer_cnt, n);
  endtask

  task automatic wait_done(input int n);
    int c = 0;
    while (done_cnt < n && c < 2000) begin @(posedge clk); #1; c++; end
    check("done_wait", done_cnt, n);
  endtask

  initial begin
    int e0, d0, x0, c;
    repeat (3) @(posedge clk);
    #1;
    check("rst_number", number, 0);
    check("rst_cnt", digit_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", digit_valid, 0);
    check("rst_dout", digit_out, 0);
    check("rst_done", dial_done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Fill buffer, then overflow
    enter_full();
    check("full_cnt", digit_cnt, 11);
    check("full_number", number, FULL_NUM);
    e0 = err_cnt;
    press(4'd5);
    check("overflow_err", err_cnt, e0 + 1);
    check("overflow_number", number, FULL_NUM);

    // Backspace and clear
    press(4'hB);
    press(4'd1); press(4'd2); press(4'd3);
    press(4'hA);
    check("bs_number", number, 44'h12);
    check("bs_cnt", digit_cnt, 2);
    e0 = err_cnt;
    press(4'hA); press(4'hA);
    check("bs_no_err", err_cnt, e0);
    press(4'hA);
    check("bs_empty_err", err_cnt, e0 + 1);
    check("bs_empty_cnt", digit_cnt, 0);
    press(4'd7);
    e0 = err_cnt;
    press(4'hB);
    check("clr_number", number, 0);
    check("clr_no_err", err_cnt, e0);

    // Dial with an incomplete number
    for (int i = 0; i < 5; i++) press(4'(i + 1));
    e0 = err_cnt;
    press(4'hC);
    check("short_dial_err", err_cnt, e0 + 1);
    check("short_dial_busy", busy, 0);
    check("short_dial_cnt", digit_cnt, 5);
    press(4'hB);

    // Full dial, consumer always ready
    enter_full();
    queue_full();
    x0 = xfer_cnt; d0 = done_cnt; e0 = err_cnt;
    press(4'hC);
    wait_done(d0 + 1);
    check("dial_xfers", xfer_cnt, x0 + 11);
    check("dial_q_empty", exp_q.size(), 0);
    repeat (20) @(posedge clk);
    #1;
    check("done_single", done_cnt, d0 + 1);
    check("done_busy", busy, 1);
    check("done_number", number, FULL_NUM);
    check("done_cnt", digit_cnt, 11);
    press(4'd7);
    check("done_busy_after_key", busy, 1);
    check("done_no_err", err_cnt, e0);
    press(4'hD);
    check("hang_number", number, 0);
    check("hang_cnt", digit_cnt, 0);
    check("hang_busy", busy, 0);

    // Stall on the third digit
    enter_full();
    queue_full();
    x0 = xfer_cnt; d0 = done_cnt;
    press(4'hC);
    wait_xfer(x0 + 2);
    digit_ready = 1'b0;
    c = 0;
    while (!digit_valid && c < 100) begin @(posedge clk); #1; c++; end
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", digit_valid, 1);
      check("stall_dout", digit_out, 8);
      @(posedge clk); #1;
    end
    digit_ready = 1'b1;
    wait_done(d0 + 1);
    check("stall_xfers", xfer_cnt, x0 + 11);
    check("stall_q_empty", exp_q.size(), 0);
    press(4'hD);

    // Hang-up during the gap after the fourth digit
    enter_full();
    queue_full();
    x0 = xfer_cnt; d0 = done_cnt;
    press(4'hC);
    wait_xfer(x0 + 4);
    key_valid = 1'b1; key_code = 4'hD;
    @(posedge clk); #1;
    key_valid = 1'b0; key_code = 4'hA;
    repeat (3 * GAP + 10) @(posedge clk);
    #1;
    check("abort_xfers", xfer_cnt, x0 + 4);
    check("abort_no_done", done_cnt, d0);
    check("abort_number", number, 0);
    check("abort_cnt", digit_cnt, 0);
    check("abort_busy", busy, 0);
    check("abort_q_left", exp_q.size(), 7);
    exp_q.delete();

    // Asynchronous reset mid-SEND
    enter_full();
    queue_full();
    digit_ready = 1'b0;
    press(4'hC);
    c = 0;
    while (!digit_valid && c < 100) begin @(posedge clk); #1; c++; end
    check("pre_rst_valid", digit_valid, 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_valid", digit_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_number", number, 0);
    check("arst_cnt", digit_cnt, 0);
    check("arst_dout", digit_out, 0);
    #10;
    rst = 1'b0;
    exp_q.delete();
    digit_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

`default_nettype wire
